w_sched_ctrl: RTL and testbench
===============================

Name: w_sched_ctrl

Overview:
Sequencer for the SHA-256 message-schedule pipeline (W_middle chain) of the bitcoin miner. Accepts one mining job: a 512-bit block plus a nonce range. Issues one schedule window per cycle into the pipeline with the nonce inserted into the block, subject to an in-flight credit limit. Tracks returns from the pipeline tail and reports job completion.

Parameters:
MAX_INFLIGHT, 64, max windows issued but not yet returned via w_en_next; range 1..255
NONCE_WORD, 3, 32-bit word index (0..15) of the block replaced by the nonce
CNT_W, 8, width of the in-flight counter; must hold MAX_INFLIGHT

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
job_valid  in  1  job offered
job_ready  out  1  controller can accept a job
job_block  in  512  message words M0..M15; M0 at [31:0]
job_nonce_start  in  32  first nonce
job_nonce_count  in  32  number of nonces; 0 is legal
abort  in  1  stop issuing the current job
w_en  out  1  enable into pipeline head
w_win  out  1024  window into pipeline head
w_nonce  out  32  nonce of the current w_en, aligned with it
w_en_next  in  1  enable emerging from pipeline tail; one pulse per issued window
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at job completion
aborted  out  1  valid with done; 1 if the job ended by abort
proto_err  out  1  sticky; w_en_next received with in-flight == 0

Behaviour:
- Reset values: state=IDLE, job_ready=0, w_en=0, w_win=0, w_nonce=0, busy=0, done=0, aborted=0, proto_err=0, in-flight=0, remaining=0.
- job_ready=1 in IDLE from the first cycle after reset deasserts. All outputs are registered.
- The pipeline shares reset. Reset mid-job discards the job and all in-flight windows; no done pulse.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - On job_valid && job_ready at edge k: latch block, nonce=job_nonce_start, remaining=job_nonce_count; job_ready=0.
  - Go to ISSUE if count>0, otherwise DONE.
- ISSUE, per edge:
  - Issue when remaining>0 && in-flight<MAX_INFLIGHT && !abort.
  - On issue: w_en<=1; w_nonce<=nonce; w_win[511:0]<=block with word NONCE_WORD replaced by nonce; w_win[1023:512]<=0; nonce<=nonce+1 mod 2^32; remaining<=remaining-1.
  - Otherwise w_en<=0; w_win and w_nonce hold their values.
  - First w_en is high in the cycle after edge k+1. Back-to-back issue is sustained at 1 window/cycle while credit allows.
  - Go to DRAIN when the last window issues (remaining becomes 0), or on abort (aborted latched to 1).
- In-flight counter:
  - +1 on issue, −1 on w_en_next.
  - Both in the same cycle: unchanged.
  - w_en_next with in-flight==0: counter stays 0, proto_err<=1.
  - Never exceeds MAX_INFLIGHT.
- DRAIN: w_en=0. When in-flight==0 (including after a same-cycle last return), go to DONE.
- DONE: done=1 and aborted valid for exactly one cycle. Next state IDLE, job_ready=1, aborted cleared.
- abort is ignored in IDLE, DRAIN and DONE. job_valid is ignored while job_ready=0.
- proto_err clears only on reset.

Decomposition:
- Package w_sched_pkg:
  - state enum {IDLE, ISSUE, DRAIN, DONE}
  - WORD_W=32, BLOCK_W=512, WIN_W=1024
  - function insert_nonce(block, nonce, idx) returning the 512-bit block
- Sub-module w_credit_cnt: up/down in-flight counter with full flag (==MAX_INFLIGHT), zero flag and underflow error output. Parameterised by MAX_INFLIGHT and CNT_W.

Test Plan:
- Basic job (bench loops w_en back to w_en_next with 48-cycle delay): block words i=0x0101_0101*i, start=0x0000_0010, count=4 -> 4 consecutive w_en; w_nonce and w_win[127:96] = 0x10..0x13; all other words unchanged; w_win[1023:512]=0. One done pulse with aborted=0 after the 4th return; job_ready=1 the cycle after done.
- Credit limit (MAX_INFLIGHT=8, delay 48, count=20) -> 8 back-to-back w_en, then stall; in-flight never exceeds 8. Issue resumes one-for-one with returns; exactly 20 w_en; done after the 20th return.
- Nonce wrap: start=0xFFFF_FFFE, count=3 -> w_nonce sequence 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000.
- Zero count: count=0 accepted at edge k -> no w_en; done=1 in the cycle after edge k+1; aborted=0.
- Abort: count=100, assert abort for one cycle after the 5th w_en -> no further w_en. done with aborted=1 after the 5 outstanding returns. Abort pulsed in IDLE has no effect.
- Reset and protocol error: reset during ISSUE -> next cycle all outputs at reset values; job_ready=1 one cycle after reset deasserts. Then a w_en_next pulse in IDLE -> proto_err=1 and stays 1 until reset.

Source files
------------

// File: rtl/w_sched_pkg.sv
// Shared types and helpers for the SHA-256 message-schedule sequencer.
// Holds the controller state encoding, the datapath widths and the nonce-insertion helper.
package w_sched_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  localparam int WORD_W  = 32;
  localparam int BLOCK_W = 512;
  localparam int WIN_W   = 1024;

  // Returns the block with 32-bit word idx overwritten by the nonce.
  function automatic logic [BLOCK_W-1:0] insert_nonce(input logic [BLOCK_W-1:0] block,
                                                      input logic [WORD_W-1:0]  nonce,
                                                      input logic [3:0]         idx);
    logic [BLOCK_W-1:0] r;
    r = block;
    r[{idx, 5'd0} +: WORD_W] = nonce;
    return r;
  endfunction

endpackage

// File: rtl/w_credit_cnt.sv
// In-flight window counter for the schedule pipeline: +1 per issue, -1 per tail return.
// Flags full/empty for the sequencer and reports returns that arrive with nothing outstanding.
module w_credit_cnt #(
  parameter int MAX_INFLIGHT = 64,
  parameter int CNT_W        = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic zero,
  output logic last_ret,
  output logic underflow
);

  logic [CNT_W-1:0] cnt;
  logic             take;

  assign zero      = (cnt == '0);
  assign full      = (cnt == CNT_W'(MAX_INFLIGHT));
  // A stray return while empty is dropped so the count cannot wrap.
  assign take      = dec && !zero;
  assign underflow = dec && zero;
  assign last_ret  = take && !inc && (cnt == CNT_W'(1));

  // NOTE: sequential state uses non-blocking assignments only; simultaneous issue and return cancel.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (inc && !take) begin
      cnt <= cnt + 1'b1;
    end else if (take && !inc) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/w_sched_ctrl.sv
// Job sequencer for the W_middle schedule chain: issues one nonce-stamped window per cycle
// under an in-flight credit limit, then drains the pipeline and pulses done.
module w_sched_ctrl
  import w_sched_pkg::*;
#(
  parameter int MAX_INFLIGHT = 64,
  parameter int NONCE_WORD   = 3,
  parameter int CNT_W        = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                job_valid,
  output logic                job_ready,
  input  logic [BLOCK_W-1:0]  job_block,
  input  logic [WORD_W-1:0]   job_nonce_start,
  input  logic [WORD_W-1:0]   job_nonce_count,
  input  logic                abort,
  output logic                w_en,
  output logic [WIN_W-1:0]    w_win,
  output logic [WORD_W-1:0]   w_nonce,
  input  logic                w_en_next,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic                proto_err
);

  state_e             state;
  logic [BLOCK_W-1:0] block_q;
  logic [WORD_W-1:0]  nonce_q;
  logic [WORD_W-1:0]  remaining_q;
  logic               abort_q;

  logic full, zero, last_ret, underflow;
  logic accept, issue;

  assign accept = (state == IDLE) && job_valid && job_ready;
  assign issue  = (state == ISSUE) && (remaining_q != '0) && !full && !abort;

  w_credit_cnt #(
    .MAX_INFLIGHT (MAX_INFLIGHT),
    .CNT_W        (CNT_W)
  ) u_credit (
    .clk       (clk),
    .reset     (reset),
    .inc       (issue),
    .dec       (w_en_next),
    .full      (full),
    .zero      (zero),
    .last_ret  (last_ret),
    .underflow (underflow)
  );

  // NOTE: the latched block is pure datapath, only read after a job is accepted, so it has no reset.
  always_ff @(posedge clk) begin
    if (accept) block_q <= job_block;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      job_ready   <= 1'b0;
      w_en        <= 1'b0;
      w_win       <= '0;
      w_nonce     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      proto_err   <= 1'b0;
      nonce_q     <= '0;
      remaining_q <= '0;
      abort_q     <= 1'b0;
    end else begin
      w_en      <= issue;
      done      <= 1'b0;
      proto_err <= proto_err | underflow;
      case (state)
        IDLE: begin
          aborted <= 1'b0;
          if (accept) begin
            nonce_q     <= job_nonce_start;
            remaining_q <= job_nonce_count;
            abort_q     <= 1'b0;
            job_ready   <= 1'b0;
            busy        <= 1'b1;
            state       <= (job_nonce_count != '0) ? ISSUE : DONE;
          end else begin
            job_ready <= 1'b1;
          end
        end
        ISSUE: begin
          if (abort) begin
            abort_q <= 1'b1;
            state   <= DRAIN;
          end else if (issue) begin
            w_nonce     <= nonce_q;
            w_win       <= {{(WIN_W-BLOCK_W){1'b0}}, insert_nonce(block_q, nonce_q, 4'(NONCE_WORD))};
            nonce_q     <= nonce_q + 1'b1;
            remaining_q <= remaining_q - 1'b1;
            if (remaining_q == WORD_W'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (zero || last_ret) state <= DONE;
        end
        DONE: begin
          done    <= 1'b1;
          aborted <= abort_q;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_w_sched_ctrl.sv
// Scoreboard bench for w_sched_ctrl: the pipeline is modelled as a fixed delay line from
// w_en back to w_en_next, and a reference model predicts every window and completion.
module tb_w_sched_ctrl;

  localparam int MAXF       = 8;
  localparam int NONCE_WORD = 3;
  localparam int PIPE_D     = 48;

  typedef struct {
    logic [31:0]   nonce;
    logic [1023:0] win;
  } win_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          job_valid;
  logic          job_ready;
  logic [511:0]  job_block;
  logic [31:0]   job_nonce_start;
  logic [31:0]   job_nonce_count;
  logic          abort;
  logic          w_en;
  logic [1023:0] w_win;
  logic [31:0]   w_nonce;
  logic          w_en_next;
  logic          busy;
  logic          done;
  logic          aborted;
  logic          proto_err;

  win_t exp_q[$];
  bit   done_q[$];

  int errors = 0;
  int checks = 0;
  int out = 0;
  int max_out = 0;
  int wen_total = 0;
  int done_total = 0;
  bit prev_done = 1'b0;
  bit inject = 1'b0;
  logic [31:0] last_nonce = '0;
  logic [PIPE_D-1:0] pipe;

  w_sched_ctrl #(
    .MAX_INFLIGHT (MAXF),
    .NONCE_WORD   (NONCE_WORD),
    .CNT_W        (8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .job_valid       (job_valid),
    .job_ready       (job_ready),
    .job_block       (job_block),
    .job_nonce_start (job_nonce_start),
    .job_nonce_count (job_nonce_count),
    .abort           (abort),
    .w_en            (w_en),
    .w_win           (w_win),
    .w_nonce         (w_nonce),
    .w_en_next       (w_en_next),
    .busy            (busy),
    .done            (done),
    .aborted         (aborted),
    .proto_err       (proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: the 16 message words with the nonce word swapped, upper half of the window zero.
  function automatic logic [1023:0] make_window(input logic [511:0] blk, input logic [31:0] nonce);
    logic [31:0]   words[16];
    logic [1023:0] w;
    w = '0;
    for (int i = 0; i < 16; i++) words[i] = blk[i*32 +: 32];
    words[NONCE_WORD] = nonce;
    for (int i = 0; i < 16; i++) w[i*32 +: 32] = words[i];
    return w;
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom();
    return b;
  endfunction

  // Pipeline model: fixed-latency loopback of w_en, cleared by the shared reset.
  initial begin
    pipe      = '0;
    w_en_next = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (reset) pipe = '0;
      else       pipe = {pipe[PIPE_D-2:0], w_en};
      w_en_next = pipe[PIPE_D-1] | inject;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a window or a completion.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        out        = 0;
        prev_done  = 1'b0;
        last_nonce = '0;
        continue;
      end
      if (prev_done) check("job_ready after done", job_ready, 1);
      prev_done = done;
      if (w_en) begin
        wen_total++;
        out++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected w_en: nonce %0h with empty scoreboard", w_nonce);
        end else begin
          win_t e;
          int   bad;
          e   = exp_q.pop_front();
          bad = 0;
          for (int i = 31; i >= 0; i--) if (w_win[i*32 +: 32] !== e.win[i*32 +: 32]) bad = i;
          check("w_nonce", w_nonce, e.nonce);
          check($sformatf("w_win word %0d", bad), w_win[bad*32 +: 32], e.win[bad*32 +: 32]);
        end
        last_nonce = w_nonce;
        check("in-flight within limit", out <= MAXF, 1);
      end else begin
        check("w_nonce hold", w_nonce, last_nonce);
      end
      if (w_en_next && out > 0) out--;
      if (out > max_out) max_out = out;
      if (done) begin
        done_total++;
        if (done_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected done: aborted=%0b with empty scoreboard", aborted);
        end else begin
          check("aborted", aborted, done_q.pop_front());
        end
        check("returns before done", out, 0);
      end
    end
  end

  task automatic check_reset_vals();
    check("rst job_ready", job_ready, 0);
    check("rst w_en", w_en, 0);
    check("rst w_win", |w_win, 0);
    check("rst w_nonce", w_nonce, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst aborted", aborted, 0);
    check("rst proto_err", proto_err, 0);
  endtask

  task automatic offer_job(input logic [511:0] blk, input logic [31:0] start, input logic [31:0] cnt);
    int t;
    t = 0;
    while (!job_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!job_ready) check("job_ready timeout", job_ready, 1);
    job_valid       = 1'b1;
    job_block       = blk;
    job_nonce_start = start;
    job_nonce_count = cnt;
    @(posedge clk);
    #1;
    job_valid       = 1'b0;
    job_block       = rand_block();
    job_nonce_start = $urandom();
    job_nonce_count = $urandom();
  endtask

  // abort_after < 0: run to completion; otherwise pulse abort once that many windows are seen.
  task automatic run_job(input logic [511:0] blk, input logic [31:0] start,
                         input logic [31:0] cnt, input int abort_after);
    int n_exp, base, d0, t;
    n_exp = (abort_after >= 0) ? abort_after : int'(cnt);
    for (int i = 0; i < n_exp; i++) begin
      win_t e;
      e.nonce = start + 32'(i);
      e.win   = make_window(blk, e.nonce);
      exp_q.push_back(e);
    end
    done_q.push_back(abort_after >= 0);
    base    = wen_total;
    d0      = done_total;
    max_out = 0;
    offer_job(blk, start, cnt);
    @(negedge clk);
    if (cnt == 0) begin
      check("zero-count done early", done, 0);
      @(negedge clk);
      check("zero-count done", done, 1);
    end else begin
      check("first w_en early", w_en, 0);
      @(negedge clk);
      check("first w_en", w_en, 1);
    end
    if (abort_after >= 0) begin
      t = 0;
      while (wen_total - base < abort_after && t < 1000) begin
        @(negedge clk);
        #1;
        t++;
      end
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
    end
    t = 0;
    while (done_total == d0 && t < 3000) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("job completed", done_total - d0, 1);
    check("w_en count", wen_total - base, n_exp);
    check("scoreboard drained", exp_q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    logic [511:0] blk;
    reset           = 1'b1;
    job_valid       = 1'b0;
    job_block       = '0;
    job_nonce_start = '0;
    job_nonce_count = '0;
    abort           = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    reset = 1'b0;
    @(negedge clk);
    check("job_ready after reset", job_ready, 1);

    // Basic job with a recognisable block pattern.
    for (int i = 0; i < 16; i++) blk[i*32 +: 32] = 32'h0101_0101 * 32'(i);
    run_job(blk, 32'h0000_0010, 32'd4, -1);

    // Credit limit: peak occupancy must reach but not exceed the limit.
    run_job(rand_block(), $urandom(), 32'd20, -1);
    check("credit peak", max_out, MAXF);

    run_job(rand_block(), 32'hFFFF_FFFE, 32'd3, -1);
    run_job(rand_block(), $urandom(), 32'd0, -1);
    run_job(rand_block(), $urandom(), 32'd100, 5);

    // Abort while idle changes nothing; the following job completes normally.
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    check("idle abort busy", busy, 0);
    check("idle abort job_ready", job_ready, 1);

    for (int j = 0; j < 4; j++) run_job(rand_block(), $urandom(), 32'($urandom_range(1, 12)), -1);
    check("no proto_err in normal traffic", proto_err, 0);

    // Reset in the middle of an issuing job.
    blk = rand_block();
    for (int i = 0; i < 100; i++) begin
      win_t e;
      e.nonce = 32'h5000 + 32'(i);
      e.win   = make_window(blk, e.nonce);
      exp_q.push_back(e);
    end
    offer_job(blk, 32'h5000, 32'd100);
    repeat (10) @(negedge clk);
    check("busy mid-job", busy, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    done_q.delete();
    @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    reset = 1'b0;
    @(negedge clk);
    check("job_ready after mid-job reset", job_ready, 1);

    // Stray return while idle raises a sticky protocol error.
    @(posedge clk);
    #1;
    inject = 1'b1;
    @(posedge clk);
    #1;
    inject = 1'b0;
    @(negedge clk);
    check("proto_err set", proto_err, 1);
    repeat (5) @(negedge clk);
    check("proto_err sticky", proto_err, 1);
    check("proto_err leaves idle", busy, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
